// File: rtl/stock_cmd_initiator_if.sv
// ---------------------------------------------------------------------------
// stock_cmd_initiator_if
//
// Bundles the host request/response handshake and the shared stock command
// bus that connect the command initiator to the host decoder and the array
// of per-stock weight units.
//
//   Host request  : req_valid, req_ready, req_stock, req_cmd, req_payload
//   Host response : rsp_valid, rsp_ready, rsp_data, rsp_status
//   Stock bus     : data_valid, stock_selected, data (to units)
//                   data_ready, unit_out (from units, unit i at [40*i+39:40*i])
//
// Modports:
//   master : the initiator's view
//   slave  : the host + weight-unit side
// ---------------------------------------------------------------------------
interface stock_cmd_initiator_if #(
    parameter int NUM_STOCKS = 4,
    parameter int SEL_W      = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
);
    logic                     req_valid;
    logic                     req_ready;
    logic [SEL_W-1:0]         req_stock;
    logic [7:0]               req_cmd;
    logic [39:0]              req_payload;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [39:0]              rsp_data;
    logic [1:0]               rsp_status;

    logic                     data_valid;
    logic [NUM_STOCKS-1:0]    stock_selected;
    logic [47:0]              data;
    logic [NUM_STOCKS-1:0]    data_ready;
    logic [40*NUM_STOCKS-1:0] unit_out;

    modport master (
        input  req_valid, req_stock, req_cmd, req_payload, rsp_ready,
               data_ready, unit_out,
        output req_ready, rsp_valid, rsp_data, rsp_status,
               data_valid, stock_selected, data
    );

    modport slave (
        output req_valid, req_stock, req_cmd, req_payload, rsp_ready,
               data_ready, unit_out,
        input  req_ready, rsp_valid, rsp_data, rsp_status,
               data_valid, stock_selected, data
    );
endinterface

// File: rtl/stock_cmd_initiator.sv
// ---------------------------------------------------------------------------
// stock_cmd_initiator
//
// Accepts one host request at a time, pulses a single-cycle command onto the
// shared 48-bit stock bus with a one-hot select, waits for the selected
// unit's data_ready and returns the unit's 40-bit output with a status code.
// Exactly one pulse per accepted command, so accumulate commands are applied
// once. All outputs are registered.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : stock_cmd_initiator_if.master (host handshake + stock bus)
//
// Status codes: 0 OK, 1 TIMEOUT, 2 BAD_REQ, 3 BAD_ACK.
// ---------------------------------------------------------------------------
module stock_cmd_initiator #(
    parameter int NUM_STOCKS     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    stock_cmd_initiator_if.master        bus
);
    localparam int          SEL_W        = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
    localparam logic [31:0] NUM_STOCKS_U = NUM_STOCKS;
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0]  CMD_SET = 8'h0A;
    localparam logic [7:0]  CMD_GET = 8'h0B;
    localparam logic [7:0]  CMD_BUY = 8'h0C;
    localparam logic [7:0]  CMD_NEG = 8'h0E;

    localparam logic [39:0] ACK_DONE = 40'hCC_CCCC_CCCC;
    localparam logic [39:0] ACK_BUY  = 40'h11_1111_1111;
    localparam logic [39:0] ACK_SELL = 40'h22_2222_2222;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_TIMEOUT = 2'd1,
        RSP_BAD_REQ = 2'd2,
        RSP_BAD_ACK = 2'd3
    } status_t;

    state_t                  state, state_n;
    logic [7:0]              wait_cnt, wait_cnt_n;
    logic [SEL_W-1:0]        stock, stock_n;
    logic [7:0]              cmd, cmd_n;

    logic                    req_ready_q, req_ready_n;
    logic                    rsp_valid_q, rsp_valid_n;
    logic [39:0]             rsp_data_q, rsp_data_n;
    status_t                 rsp_status_q, rsp_status_n;
    logic                    data_valid_q, data_valid_n;
    logic [NUM_STOCKS-1:0]   stock_selected_q, stock_selected_n;
    logic [47:0]             data_q, data_n;

    logic                    req_legal;
    logic                    ready_sel;
    logic [39:0]             unit_slice;

    assign req_legal  = (bus.req_cmd >= CMD_SET) && (bus.req_cmd <= CMD_NEG)
                     && (32'(bus.req_stock) < NUM_STOCKS_U);
    // Only the addressed unit's ready/output matter; other units are ignored.
    assign ready_sel  = bus.data_ready[stock];
    assign unit_slice = bus.unit_out[40*stock +: 40];

    assign bus.req_ready      = req_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_status     = rsp_status_q;
    assign bus.data_valid     = data_valid_q;
    assign bus.stock_selected = stock_selected_q;
    assign bus.data           = data_q;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_n          = state;
        wait_cnt_n       = wait_cnt;
        stock_n          = stock;
        cmd_n            = cmd;
        req_ready_n      = req_ready_q;
        rsp_valid_n      = rsp_valid_q;
        rsp_data_n       = rsp_data_q;
        rsp_status_n     = rsp_status_q;
        // Bus outputs default low every cycle, which makes the strobe a
        // single-cycle pulse by construction.
        data_valid_n     = 1'b0;
        stock_selected_n = '0;
        data_n           = '0;

        case (state)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    stock_n     = bus.req_stock;
                    cmd_n       = bus.req_cmd;
                    req_ready_n = 1'b0;
                    if (req_legal) begin
                        // Pulse is registered here so it appears in ISSUE.
                        state_n                         = S_ISSUE;
                        data_valid_n                    = 1'b1;
                        stock_selected_n[bus.req_stock] = 1'b1;
                        data_n                          = {bus.req_cmd, bus.req_payload};
                    end else begin
                        state_n      = S_RESP;
                        rsp_valid_n  = 1'b1;
                        rsp_data_n   = '0;
                        rsp_status_n = RSP_BAD_REQ;
                    end
                end
            end

            S_ISSUE: begin
                state_n    = S_WAIT;
                wait_cnt_n = '0;
            end

            S_WAIT: begin
                // Ready wins over the timeout in the last counted cycle.
                if (ready_sel) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = unit_slice;
                    case (cmd)
                        CMD_GET: rsp_status_n = RSP_OK;
                        CMD_BUY: rsp_status_n = (unit_slice == ACK_BUY || unit_slice == ACK_SELL)
                                              ? RSP_OK : RSP_BAD_ACK;
                        default: rsp_status_n = (unit_slice == ACK_DONE) ? RSP_OK : RSP_BAD_ACK;
                    endcase
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    state_n      = S_RESP;
                    rsp_valid_n  = 1'b1;
                    rsp_data_n   = '0;
                    rsp_status_n = RSP_TIMEOUT;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_n     = S_IDLE;
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; the
        // combinational block above uses blocking ones.
        if (rst) begin
            state            <= S_IDLE;
            wait_cnt         <= '0;
            stock            <= '0;
            cmd              <= '0;
            req_ready_q      <= 1'b1;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= '0;
            rsp_status_q     <= RSP_OK;
            data_valid_q     <= 1'b0;
            stock_selected_q <= '0;
            data_q           <= '0;
        end else begin
            state            <= state_n;
            wait_cnt         <= wait_cnt_n;
            stock            <= stock_n;
            cmd              <= cmd_n;
            req_ready_q      <= req_ready_n;
            rsp_valid_q      <= rsp_valid_n;
            rsp_data_q       <= rsp_data_n;
            rsp_status_q     <= rsp_status_n;
            data_valid_q     <= data_valid_n;
            stock_selected_q <= stock_selected_n;
            data_q           <= data_n;
        end
    end
endmodule

// File: tb/tb_stock_cmd_initiator.sv
// ---------------------------------------------------------------------------
// tb_stock_cmd_initiator
//
// Directed bench for stock_cmd_initiator. A four-unit instance is driven
// against behavioural weight units with programmable ready delay; a
// three-unit instance exercises the out-of-range stock index. Expected
// responses (data, status, latency from acceptance) are queued when a
// request is issued and popped by a monitor when rsp_valid rises.
// ---------------------------------------------------------------------------
module tb_stock_cmd_initiator;
    localparam int NS = 4;

    typedef struct {
        logic [39:0] data;
        logic [1:0]  status;
        int          lat;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stock_cmd_initiator_if #(.NUM_STOCKS(NS)) bus ();
    stock_cmd_initiator_if #(.NUM_STOCKS(3))  bus3 ();

    stock_cmd_initiator #(.NUM_STOCKS(NS), .TIMEOUT_CYCLES(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    stock_cmd_initiator #(.NUM_STOCKS(3), .TIMEOUT_CYCLES(15)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- weight-unit models ----------------
    logic [39:0]   weights [NS];
    logic [39:0]   unit_q  [NS];
    logic [39:0]   pend    [NS];
    int            dly     [NS];   // 0 = never answer, d = ready in d-th cycle after strobe
    int            cnt_u   [NS];
    logic [NS-1:0] unit_rdy;
    logic [NS-1:0] inj_rdy;
    bit            bad_ack;

    assign bus.data_ready = unit_rdy | inj_rdy;
    assign bus.unit_out   = {unit_q[3], unit_q[2], unit_q[1], unit_q[0]};

    task automatic unit_exec(input logic [39:0] w, input logic [47:0] d,
                             output logic [39:0] nw, output logic [39:0] r);
        int dot;
        logic [39:0] p;
        p   = d[39:0];
        nw  = w;
        r   = '0;
        dot = 0;
        case (d[47:40])
            8'h0A: begin nw = p; r = 40'hCC_CCCC_CCCC; end
            8'h0B: r = w;
            8'h0C: begin
                for (int b = 0; b < 5; b++) dot += int'(w[8*b +: 8]) * int'(p[8*b +: 8]);
                r = (dot > 2) ? 40'h11_1111_1111 : 40'h22_2222_2222;
            end
            8'h0D: begin
                for (int b = 0; b < 5; b++) nw[8*b +: 8] = w[8*b +: 8] + p[8*b +: 8];
                r = 40'hCC_CCCC_CCCC;
            end
            8'h0E: begin
                for (int b = 0; b < 5; b++) nw[8*b +: 8] = w[8*b +: 8] - p[8*b +: 8];
                r = 40'hCC_CCCC_CCCC;
            end
            default: r = '0;
        endcase
        if (bad_ack) r = r ^ 40'h1;
    endtask

    always @(posedge clk) begin : unit_model
        logic [39:0] nw, r;
        for (int i = 0; i < NS; i++) begin
            unit_rdy[i] <= 1'b0;
            if (bus.data_valid && bus.stock_selected[i]) begin
                unit_exec(weights[i], bus.data, nw, r);
                weights[i] <= nw;
                if (dly[i] == 1) begin
                    unit_rdy[i] <= 1'b1;
                    unit_q[i]   <= r;
                end else if (dly[i] > 1) begin
                    cnt_u[i] <= dly[i] - 1;
                    pend[i]  <= r;
                end
            end else if (cnt_u[i] != 0) begin
                cnt_u[i] <= cnt_u[i] - 1;
                if (cnt_u[i] == 1) begin
                    unit_rdy[i] <= 1'b1;
                    unit_q[i]   <= pend[i];
                end
            end
        end
    end

    // ---------------- acceptance timestamps ----------------
    int cyc = 0, acc_cyc = 0, acc3_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.req_valid && bus.req_ready)   acc_cyc  <= cyc;
        if (bus3.req_valid && bus3.req_ready) acc3_cyc <= cyc;
    end

    // ---------------- scoreboard monitors ----------------
    exp_t        q  [$];
    exp_t        q3 [$];
    logic [3:0]  exp_sel;
    logic [47:0] exp_bus;
    int          dv_seen = 0;
    int          exp_dv  = 0;
    bit          prev_rv = 0, prev_dv = 0, prev_rv3 = 0;
    logic [39:0] hold_data;
    logic [1:0]  hold_status;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.rsp_valid) begin
            check("req_ready_busy", 64'(bus.req_ready), 64'(0));
            if (!prev_rv) begin
                check("rsp_expected", 64'(q.size() > 0), 64'(1));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check({e.name, "_data"},    64'(bus.rsp_data),   64'(e.data));
                    check({e.name, "_status"},  64'(bus.rsp_status), 64'(e.status));
                    check({e.name, "_latency"}, 64'(cyc - acc_cyc),  64'(e.lat));
                end
                hold_data   = bus.rsp_data;
                hold_status = bus.rsp_status;
            end else begin
                check("rsp_data_stable",   64'(bus.rsp_data),   64'(hold_data));
                check("rsp_status_stable", 64'(bus.rsp_status), 64'(hold_status));
            end
        end
        prev_rv = bus.rsp_valid;

        if (bus.data_valid) begin
            dv_seen++;
            check("dv_single",      64'(prev_dv),            64'(0));
            check("stock_selected", 64'(bus.stock_selected), 64'(exp_sel));
            check("bus_data",       64'(bus.data),           64'(exp_bus));
        end else begin
            check("bus_idle", 64'({bus.stock_selected, bus.data}), 64'(0));
        end
        prev_dv = bus.data_valid;
    end

    always @(negedge clk) begin : monitor3
        exp_t e;
        check("dut3_data_valid", 64'(bus3.data_valid), 64'(0));
        if (bus3.rsp_valid && !prev_rv3) begin
            check("dut3_rsp_expected", 64'(q3.size() > 0), 64'(1));
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check({e.name, "_data"},    64'(bus3.rsp_data),   64'(e.data));
                check({e.name, "_status"},  64'(bus3.rsp_status), 64'(e.status));
                check({e.name, "_latency"}, 64'(cyc - acc3_cyc),  64'(e.lat));
            end
        end
        prev_rv3 = bus3.rsp_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] s, input logic [7:0] c, input logic [39:0] p,
                        input logic [39:0] ed, input logic [1:0] es, input int lat,
                        input string nm, input bit expect_rsp);
        exp_t e;
        int guard;
        if (expect_rsp) begin
            e.data = ed; e.status = es; e.lat = lat; e.name = nm;
            q.push_back(e);
        end
        if (c >= 8'h0A && c <= 8'h0E) exp_dv++;
        exp_sel = 4'b0001 << s;
        exp_bus = {c, p};
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_stock   = s;
        bus.req_cmd     = c;
        bus.req_payload = p;
        guard = 0;
        while (!bus.req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check({nm, "_accept"}, 64'(guard < 300), 64'(1));
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check({nm, "_done"}, 64'(guard < 300), 64'(1));
    endtask

    task automatic txn(input logic [1:0] s, input logic [7:0] c, input logic [39:0] p,
                       input logic [39:0] ed, input logic [1:0] es, input int lat,
                       input string nm);
        send(s, c, p, ed, es, lat, nm, 1'b1);
        wait_idle(nm);
    endtask

    task automatic pulse_inj(input int u);
        @(negedge clk);
        inj_rdy[u] = 1'b1;
        @(negedge clk);
        inj_rdy[u] = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    localparam logic [39:0] ACK  = 40'hCC_CCCC_CCCC;
    localparam logic [39:0] BUY  = 40'h11_1111_1111;
    localparam logic [39:0] SELL = 40'h22_2222_2222;

    initial begin
        exp_t e3;
        int   guard;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_stock = '0; bus.req_cmd = '0; bus.req_payload = '0;
        bus.rsp_ready = 1'b1;
        bus3.req_valid = 1'b0; bus3.req_stock = '0; bus3.req_cmd = '0; bus3.req_payload = '0;
        bus3.rsp_ready = 1'b1; bus3.data_ready = '0; bus3.unit_out = '0;
        inj_rdy = '0; unit_rdy = '0; bad_ack = 1'b0;
        exp_sel = '0; exp_bus = '0;
        for (int i = 0; i < NS; i++) begin
            weights[i] = '0; unit_q[i] = '0; pend[i] = '0; cnt_u[i] = 0; dly[i] = 1;
        end

        repeat (3) @(negedge clk);
        check("rst_req_ready",      64'(bus.req_ready),      64'(1));
        check("rst_rsp_valid",      64'(bus.rsp_valid),      64'(0));
        check("rst_rsp_data",       64'(bus.rsp_data),       64'(0));
        check("rst_rsp_status",     64'(bus.rsp_status),     64'(0));
        check("rst_data_valid",     64'(bus.data_valid),     64'(0));
        check("rst_stock_selected", 64'(bus.stock_selected), 64'(0));
        check("rst_data",           64'(bus.data),           64'(0));
        rst = 1'b0;

        // SET then GET on stock 2
        txn(2'd2, 8'h0A, 40'h05_0403_0201, ACK,            2'd0, 3, "set2");
        txn(2'd2, 8'h0B, 40'h0,            40'h0504030201, 2'd0, 3, "get2");

        // CALC_BUY decisions
        txn(2'd0, 8'h0A, 40'h01_0101_0101, ACK,  2'd0, 3, "set0");
        txn(2'd0, 8'h0C, 40'h00_0000_0001, SELL, 2'd0, 3, "buy_sell");
        txn(2'd0, 8'h0C, 40'h01_0101_0101, BUY,  2'd0, 3, "buy_buy");

        // CALC_POS with a stalled response, applied once
        txn(2'd2, 8'h0A, 40'h0A_0A0A_0A0A, ACK, 2'd0, 3, "set2b");
        bus.rsp_ready = 1'b0;
        send(2'd2, 8'h0D, 40'h01_0101_0101, ACK, 2'd0, 3, "pos_stall", 1'b1);
        repeat (12) @(negedge clk);
        bus.rsp_ready = 1'b1;
        wait_idle("pos_stall");
        txn(2'd2, 8'h0B, 40'h0, 40'h0B0B0B0B0B, 2'd0, 3, "get_after_pos");
        txn(2'd2, 8'h0E, 40'h01_0101_0101, ACK, 2'd0, 3, "neg2");
        txn(2'd2, 8'h0B, 40'h0, 40'h0A0A0A0A0A, 2'd0, 3, "get_after_neg");

        // Bad commands on either side of the legal range
        txn(2'd1, 8'h0F, 40'h12_3456_789A, 40'h0, 2'd2, 1, "bad_cmd_0f");
        txn(2'd1, 8'h09, 40'h12_3456_789A, 40'h0, 2'd2, 1, "bad_cmd_09");

        // Out-of-range stock on the three-unit instance
        e3.data = '0; e3.status = 2'd2; e3.lat = 1; e3.name = "bad_stock3";
        q3.push_back(e3);
        @(negedge clk);
        bus3.req_valid = 1'b1; bus3.req_stock = 2'd3; bus3.req_cmd = 8'h0A;
        bus3.req_payload = 40'hFF_FFFF_FFFF;
        guard = 0;
        while (!bus3.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bad_stock3_accept", 64'(guard < 50), 64'(1));
        @(negedge clk);
        bus3.req_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Timeout and late ready
        txn(2'd1, 8'h0A, 40'h11_2233_4455, ACK, 2'd0, 3, "set1");
        dly[1] = 0;
        txn(2'd1, 8'h0B, 40'h0, 40'h0, 2'd1, 17, "timeout");
        pulse_inj(1);
        repeat (5) @(negedge clk);
        dly[1] = 15;
        txn(2'd1, 8'h0B, 40'h0, 40'h1122334455, 2'd0, 17, "ready_last_cycle");
        dly[1] = 16;
        txn(2'd1, 8'h0B, 40'h0, 40'h0, 2'd1, 17, "ready_one_late");
        repeat (4) @(negedge clk);
        dly[1] = 1;

        // Cross-talk: ready from unit 1 while waiting on unit 0
        dly[0] = 6;
        send(2'd0, 8'h0B, 40'h0, 40'h0101010101, 2'd0, 8, "crosstalk", 1'b1);
        pulse_inj(1);
        wait_idle("crosstalk");
        dly[0] = 1;

        // Unexpected acknowledge values
        bad_ack = 1'b1;
        txn(2'd3, 8'h0A, 40'h01_0203_0405, 40'hCCCCCCCCCD, 2'd3, 3, "set_bad_ack");
        txn(2'd3, 8'h0C, 40'h00_0000_0000, 40'h2222222223, 2'd3, 3, "buy_bad_ack");
        bad_ack = 1'b0;

        // Reset in WAIT, late ready afterwards
        dly[0] = 5;
        send(2'd0, 8'h0B, 40'h0, 40'h0, 2'd0, 0, "rst_abandon", 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("wait_rst_req_ready",      64'(bus.req_ready),      64'(1));
        check("wait_rst_rsp_valid",      64'(bus.rsp_valid),      64'(0));
        check("wait_rst_rsp_data",       64'(bus.rsp_data),       64'(0));
        check("wait_rst_rsp_status",     64'(bus.rsp_status),     64'(0));
        check("wait_rst_data_valid",     64'(bus.data_valid),     64'(0));
        check("wait_rst_stock_selected", 64'(bus.stock_selected), 64'(0));
        check("wait_rst_data",           64'(bus.data),           64'(0));
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_req_ready", 64'(bus.req_ready), 64'(1));
        dly[0] = 1;

        // Final accounting
        check("pending_responses", 64'(q.size() + q3.size()), 64'(0));
        check("strobe_count",      64'(dv_seen),              64'(exp_dv));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/stock_cmd_initiator.md
# stock_cmd_initiator

Command initiator for the trading engine's per-stock weight units: accepts one host request at a time, drives a single-cycle command onto the shared 48-bit stock command bus with a one-hot stock select, waits for the selected unit's `data_ready`, and returns its 40-bit response with a status code. It sits between the host/UART command decoder and the array of weight units. It enforces the one-pulse-per-command rule, so accumulate commands (`CALC_WEIGHTS_POS` / `CALC_WEIGHTS_NEG`) are applied exactly once.

## Interface
- `NUM_STOCKS`, 4: number of attached weight units; `SEL_W = $clog2(NUM_STOCKS)`.
- `TIMEOUT_CYCLES`, 15: number of WAIT cycles without `data_ready` before a timeout is declared (range 1–255).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: initiator can accept a request.
- `req_stock` in SEL_W: target stock index.
- `req_cmd` in 8: command byte. Legal values are 0x0A (SET), 0x0B (GET), 0x0C (CALC_BUY), 0x0D (CALC_POS) and 0x0E (CALC_NEG).
- `req_payload` in 40: five 8-bit fields: [7:0] company, [15:8] four, [23:16] profit, [31:24] twitter, [39:32] moving.
- `rsp_valid` out 1: response valid; held until accepted.
- `rsp_ready` in 1: host accepts the response.
- `rsp_data` out 40: captured unit output, or 0 on error.
- `rsp_status` out 2: 0 = OK, 1 = TIMEOUT, 2 = BAD_REQ, 3 = BAD_ACK.
- `data_valid` out 1: command strobe to the weight units.
- `stock_selected` out NUM_STOCKS: one-hot select.
- `data` out 48: {cmd, payload}.
- `data_ready` in NUM_STOCKS: per-unit ready.
- `unit_out` in 40*NUM_STOCKS: per-unit outputs, flattened; unit i occupies [40*i+39:40*i].

## Operation
- All outputs are registered. Reset values:
  - `req_ready` = 1.
  - `rsp_valid`, `rsp_data`, `rsp_status` = 0.
  - `data_valid`, `stock_selected`, `data` = 0.
  - FSM in IDLE, timeout counter = 0.
- **IDLE**: `req_ready` = 1. On `req_valid & req_ready`, latch the stock index, command and payload, and drop `req_ready`.
  - If `req_cmd` is not 0x0A–0x0E, or `req_stock >= NUM_STOCKS`, go to RESP with status 2 and data 0. Nothing is driven on the bus.
  - Otherwise go to ISSUE.
- **ISSUE** (exactly one cycle):
  - `data_valid` = 1, `stock_selected` = 1 << stock, `data` = {cmd, payload}.
  - Go to WAIT and clear the counter.
  - `data_valid`, `stock_selected` and `data` return to 0 on the following cycle.
- **WAIT**:
  - Only `data_ready[stock]` is honoured; ready bits from other units are ignored.
  - On `data_ready[stock]`, capture the `unit_out` slice and go to RESP.
    - For SET, CALC_POS and CALC_NEG, the status is 0 if the slice equals 0xCCCCCCCCCC, otherwise 3. In both cases `rsp_data` = the captured value.
    - For GET, the status is 0 and `rsp_data` = the stored weights.
    - For CALC_BUY, the status is 0 if the slice is 0x1111111111 (buy) or 0x2222222222 (sell), otherwise 3.
  - If ready is absent and the counter equals TIMEOUT_CYCLES−1, go to RESP with status 1 and data 0.
  - Otherwise increment the counter.
  - A ready that arrives in the final counted cycle takes precedence over the timeout.
- **RESP**:
  - `rsp_valid` = 1. `rsp_data` and `rsp_status` are held stable.
  - On `rsp_ready`, drop `rsp_valid`, raise `req_ready` and go to IDLE.
  - A new request can be accepted no earlier than the cycle after `rsp_valid` falls.
- A `data_ready` that arrives in IDLE, ISSUE or RESP (stale or spurious) is ignored and never generates a response.
- `rst` asserted in any state immediately forces all reset values. Any command already pulsed on the bus is abandoned, and its late ready is ignored.

## Timing
- Handshakes complete on the rising edge where valid & ready are both high.
- Normal transaction, with the request accepted at edge E0:
  - `data_valid` is high in the cycle after E0.
  - The weight unit asserts `data_ready` in the following cycle.
  - `rsp_valid` rises one cycle later, 3 cycles after E0.
- BAD_REQ: `rsp_valid` is high in the cycle after E0.
- TIMEOUT: `rsp_valid` is high TIMEOUT_CYCLES+2 cycles after E0.
- `data_valid` is never high for more than one consecutive cycle. `stock_selected` is one-hot only when `data_valid` = 1, and all-zero otherwise.
- At most one command is in flight; `req_ready` stays 0 from acceptance until the response handshake.

## Test plan
- **SET then GET**:
  - Stimulus: SET stock 2 with payload 0x0504030201, then GET stock 2.
  - Required response: SET completes with status 0 and data 0xCCCCCCCCCC. GET completes with status 0 and data 0x0504030201.
  - Check: `data_valid` is high for exactly one cycle per request, and `stock_selected` = 4'b0100.
- **CALC_BUY decision**:
  - Stimulus: weights set to 0x0101010101, then CALC_BUY with payload 0x0000000001, then CALC_BUY with payload 0x0101010101.
  - Required response: the first returns 0x2222222222 (sell); the second returns 0x1111111111 (buy). Both have status 0.
  - Check: `rsp_valid` rises 3 cycles after acceptance.
- **CALC_POS applied once**:
  - Stimulus: weights set to 0x0A0A0A0A0A, CALC_POS with payload 0x0101010101, with `rsp_ready` held low for 10 cycles, then GET.
  - Required response: GET returns 0x0B0B0B0B0B; the increment is not applied twice.
  - Check: `rsp_valid` and `rsp_data` stay stable throughout the stall.
- **Bad requests**:
  - Stimulus: a request with `req_cmd` = 0x0F, then a request with `req_stock` = 3 and `NUM_STOCKS` = 3.
  - Required response: status 2 and data 0 for both, one cycle after acceptance, with `data_valid` never asserted.
- **Timeout**:
  - Stimulus: a bench model of unit 1 that never asserts `data_ready`; `TIMEOUT_CYCLES` = 15.
  - Required response: status 1 with `rsp_valid` rising 17 cycles after acceptance. A `data_ready[1]` injected afterwards produces no response.
  - Repeat with ready delayed to exactly the 15th WAIT cycle: the response is status 0 with the delivered data.
- **Reset and cross-talk**:
  - Stimulus: assert `rst` in the WAIT state, then release it.
  - Required response: all outputs return to reset values on the next edge, and the late ready from the abandoned command is ignored.
  - Stimulus: during WAIT on stock 0, pulse `data_ready[1]`.
  - Required response: no response is generated.
